serial_tx_8bits: RTL

Parallel-in, serial-out byte transmitter that produces the single-bit stream consumed by the 8-bit super register's serial shift inputs (in_shift_right / in_shift_left). A byte is accepted via a valid/ready handshake, then emitted one bit per clock, LSB-first or MSB-first, with a per-bit strobe, a last-bit marker, a stall input and a one-cycle completion pulse. It is the driving end of the datapath's serial shift link.

---
 rtl/serial_tx_8bits.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_tx_8bits.sv
// serial_tx_8bits: parallel-in, serial-out byte transmitter.
// Accepts a byte on a valid/ready handshake and emits it one bit per clock,
// LSB-first or MSB-first, with a per-bit strobe, a last-bit marker, a stall
// input and a one-cycle completion pulse.
// Optional feature macro: PARITY_EN appends an even-parity bit as a 9th bit.
module serial_tx_8bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       msb_first,
  input  logic       pause,
  output logic       out_serial,
  output logic       out_valid,
  output logic       out_last,
  output logic       done
);

`ifdef PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t     state_q;
  logic [7:0] sreg_q;
  logic [7:0] sreg_d;
  logic [2:0] cnt_q;
  logic       msb_q;
  logic       in_ready_q;
  logic       emit_q;
  logic       last_q;
  logic       done_q;
  logic       cur_bit;
`ifdef PARITY_EN
  logic       parity_q;
`endif

  // Shift register advanced toward the emitting end, zero-filled
  always_comb begin
    sreg_d = msb_q ? {sreg_q[6:0], 1'b0} : {1'b0, sreg_q[7:1]};
  end

  // Frame FSM with registered output flags (emit/last/done/ready)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      msb_q      <= 1'b0;
      in_ready_q <= 1'b1;
      emit_q     <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sreg_q     <= in_data;
            msb_q      <= msb_first;
            cnt_q      <= '0;
`ifdef PARITY_EN
            parity_q   <= ^in_data;
`endif
            in_ready_q <= 1'b0;
            emit_q     <= 1'b1;
            last_q     <= 1'b0;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!pause) begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
`ifdef PARITY_EN
              last_q  <= 1'b1;
              state_q <= S_PARITY;
`else
              emit_q  <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
`endif
            end else begin
`ifndef PARITY_EN
              // Flag is registered, so it is raised one bit early
              last_q <= (cnt_q == 3'd6);
`endif
            end
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          if (!pause) begin
            emit_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          emit_q     <= 1'b0;
          last_q     <= 1'b0;
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Select the bit currently at the emitting end (or the parity bit)
  always_comb begin
    cur_bit = msb_q ? sreg_q[7] : sreg_q[0];
`ifdef PARITY_EN
    if (state_q == S_PARITY) cur_bit = parity_q;
`endif
  end

  assign in_ready   = in_ready_q;
  assign done       = done_q;
  assign out_valid  = emit_q & ~pause;
  assign out_last   = last_q & ~pause;
  assign out_serial = emit_q & ~pause & cur_bit;

endmodule
